// File: rtl/tdm_pkg.sv
// Shared constants and state type for the TDM serial link (input and output ends).
// NCH and WIDTH must both be powers of two so channel/bit fields slice out of the bit count.
package tdm_pkg;
  localparam int NCH   = 32;
  localparam int WIDTH = 8;
  localparam int FBITS = NCH * WIDTH;
  localparam int CHW   = $clog2(NCH);
  localparam int BITW  = $clog2(WIDTH);
  localparam int BCW   = $clog2(FBITS);

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } tdm_state_e;
endpackage

// File: rtl/tdm_frame_buf.sv
// Two-bank channel word store: one write port into the fill bank, one read port
// into the active bank. Contents are data only and carry no reset.
module tdm_frame_buf
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_bank,
  input  logic [CHW-1:0]   rd_ch,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem_q [2][NCH];
  logic [WIDTH-1:0] mem_d [2][NCH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_bank][wr_ch] = wr_data;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_bank][rd_ch];
endmodule

// File: rtl/tdm_serial_out.sv
// TDM transmit serializer: shifts the committed frame bank out MSB-first, aligned
// to fs/bit_en, with bank swap on commit and underrun/sync error reporting.
module tdm_serial_out
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             fs,
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_commit,
  output logic             tdm_out,
  output logic             tdm_oe,
  output logic             underrun,
  output logic             sync_err
);
  tdm_state_e       state_q, state_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic             bank_q, bank_d;
  logic             commit_pend_q, commit_pend_d;
  logic             tdm_out_q, tdm_out_d;
  logic             underrun_q, underrun_d;
  logic             sync_err_q, sync_err_d;

  logic             frame_start;
  logic             advance;
  logic             swap;
  logic [CHW-1:0]   rd_ch;
  logic [BITW-1:0]  rd_bit;
  logic [WIDTH-1:0] rd_word;

  assign frame_start = bit_en & fs;
  assign advance     = bit_en & ~fs & (state_q == SYNC);
  // A commit arriving in the fs clock itself is not taken until the next fs.
  assign swap        = frame_start & commit_pend_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= HUNT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == HUNT && frame_start) state_d = SYNC;
  end

  always_comb begin
    tdm_oe   = (state_q == SYNC);
    tdm_out  = tdm_out_q;
    underrun = underrun_q;
    sync_err = sync_err_q;
  end

  always_comb begin
    bank_d        = swap ? ~bank_q : bank_q;
    commit_pend_d = commit_pend_q;
    if (swap)      commit_pend_d = 1'b0;
    if (wr_commit) commit_pend_d = 1'b1;

    bit_cnt_d = bit_cnt_q;
    if (frame_start)  bit_cnt_d = '0;
    else if (advance) bit_cnt_d = bit_cnt_q + BCW'(1);

    underrun_d = frame_start & ~commit_pend_q & ~wr_commit;
    sync_err_d = frame_start & (state_q == SYNC) & (bit_cnt_q != BCW'(FBITS - 1));
  end

  // The read address is the post-update count so the new bit lands one clk after bit_en.
  assign rd_ch  = bit_cnt_d[BCW-1:BITW];
  assign rd_bit = bit_cnt_d[BITW-1:0];

  always_comb begin
    tdm_out_d = tdm_out_q;
    if (frame_start || advance) tdm_out_d = rd_word[~rd_bit];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q     <= '0;
      bank_q        <= 1'b0;
      commit_pend_q <= 1'b0;
      tdm_out_q     <= 1'b0;
      underrun_q    <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      bank_q        <= bank_d;
      commit_pend_q <= commit_pend_d;
      tdm_out_q     <= tdm_out_d;
      underrun_q    <= underrun_d;
      sync_err_q    <= sync_err_d;
    end
  end

  // Writes target whichever bank is the fill bank after any swap in this clk.
  tdm_frame_buf u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_bank (~bank_d),
    .wr_ch   (wr_ch),
    .wr_data (wr_data),
    .rd_bank (bank_d),
    .rd_ch   (rd_ch),
    .rd_data (rd_word)
  );
endmodule
